axi_round_clip_p: RTL and testbench

- Post-multiplier conditioning stage; sits directly downstream of the DSP48 mult-add block.
- Consumes its wide accumulator output stream (p_tdata/p_tlast/p_tvalid/p_tready) and produces a narrow, rounded, saturated AXI-Stream sample.
- Flags clipped samples and keeps a saturating clip-event counter for status readback.
- Two-stage register pipeline with full-throughput backpressure.

---
 rtl/rfnoc_dsp_pkg.sv | 22 ++
 rtl/axi_pipe_slice.sv | 70 +++++++
 rtl/axi_round_clip_p.sv | 165 ++++++++++++++++
 tb/tb_axi_round_clip_p.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfnoc_dsp_pkg.sv
// Shared constants and helpers for the DSP conditioning stages.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rfnoc_dsp_pkg;

  // Rounding modes for fixed-point narrowing.
  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Largest two's-complement value representable in w bits (w <= 63).
  function automatic logic signed [63:0] signed_max(input int w);
    logic signed [63:0] one;
    one = 64'sd1;
    return (one <<< (w - 1)) - one;
  endfunction

  // Smallest two's-complement value representable in w bits (w <= 63).
  function automatic logic signed [63:0] signed_min(input int w);
    return -signed_max(w) - 64'sd1;
  endfunction

endpackage

// File: rtl/axi_pipe_slice.sv
// Single valid/ready register slice with a generic payload.
// Latency: 1 clk from input transfer to out_vld_o.
// Backpressure: in_rdy_o = ~full | out_rdy_i, so full rate with one entry of storage.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   in_dat_i/vld_i/rdy_o   upstream payload and handshake
//   out_dat_o/vld_o/rdy_i  downstream payload and handshake
module axi_pipe_slice #(
  parameter int W         = 8,
  parameter bit RESET_DAT = 1'b0  // 1: payload register clears to 0 on reset
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] in_dat_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  output logic [W-1:0] out_dat_o,
  output logic         out_vld_o,
  input  logic         out_rdy_i
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;
  logic         adv;

  // The slot can take a new beat when empty or when its beat leaves this cycle.
  assign adv = ~vld_q | out_rdy_i;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (adv) begin
      vld_d = in_vld_i;
      // Only capture on a real transfer so idle cycles don't disturb the payload.
      if (in_vld_i) begin
        dat_d = in_dat_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  generate
    if (RESET_DAT) begin : g_dat_rst
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dat_q <= '0;
        end else begin
          dat_q <= dat_d;
        end
      end
    end else begin : g_dat_norst
      always_ff @(posedge clk) begin
        dat_q <= dat_d;
      end
    end
  endgenerate

  assign in_rdy_o  = adv;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

endmodule

// File: rtl/axi_round_clip_p.sv
// Round, arithmetic-shift and saturate a wide accumulator stream to a narrow sample; counts clips.
// Latency: 2 clk from input transfer to o_tvalid; one sample per clk with o_tready high.
// Backpressure: two-entry pipeline; i_tready drops only when both stages hold data and o_tready is low.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   clear                             synchronous clear of clip_cnt / clip_sticky
//   i_tdata/i_tlast/i_tvalid/i_tready wide input stream
//   o_tdata/o_tlast/o_tuser/o_tvalid/o_tready  narrow output stream, o_tuser = clipped
//   clip_sticky, clip_cnt             clip status (sticky flag, saturating counter)
module axi_round_clip_p
  import rfnoc_dsp_pkg::*;
#(
  parameter int WIDTH_IN  = 48,
  parameter int WIDTH_OUT = 16,
  parameter int SHIFT     = 15,
  parameter int ROUND     = ROUND_HALF_UP,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [WIDTH_IN-1:0]  i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [WIDTH_OUT-1:0] o_tdata,
  output logic                 o_tlast,
  output logic                 o_tuser,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 clip_sticky,
  output logic [CNT_W-1:0]     clip_cnt
);

  localparam int S1_W = WIDTH_IN + 2;   // {tlast, sum[WIDTH_IN:0]}
  localparam int S2_W = WIDTH_OUT + 2;  // {clip, tlast, sample}

  localparam logic signed [63:0] MAX64 = signed_max(WIDTH_OUT);
  localparam logic signed [63:0] MIN64 = signed_min(WIDTH_OUT);

  // Clip limits expressed at the width of the shifted sum so the compare is a plain signed compare.
  localparam logic signed [WIDTH_IN:0] MAX_R = MAX64[WIDTH_IN:0];
  localparam logic signed [WIDTH_IN:0] MIN_R = MIN64[WIDTH_IN:0];

  localparam logic [WIDTH_OUT-1:0] SAT_POS = MAX64[WIDTH_OUT-1:0];
  localparam logic [WIDTH_OUT-1:0] SAT_NEG = MIN64[WIDTH_OUT-1:0];

  localparam logic [WIDTH_IN:0] RND_ONE = {{WIDTH_IN{1'b0}}, 1'b1};
  localparam logic [WIDTH_IN:0] RND_ADD = (ROUND == ROUND_HALF_UP) ? (RND_ONE << (SHIFT - 1)) : '0;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Stage 1: sign-extend by one bit, then add the rounding offset. The extra
  // bit keeps positive full scale plus the half-LSB offset from wrapping.
  // ---------------------------------------------------------------------------
  logic [WIDTH_IN:0] s1_ext;
  logic [WIDTH_IN:0] s1_sum;

  assign s1_ext = {i_tdata[WIDTH_IN-1], i_tdata};
  assign s1_sum = s1_ext + RND_ADD;

  logic [S1_W-1:0] s1_dat;
  logic            s1_vld;
  logic            s2_rdy;

  axi_pipe_slice #(
    .W         (S1_W),
    .RESET_DAT (1'b0)
  ) u_s1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_dat_i  ({i_tlast, s1_sum}),
    .in_vld_i  (i_tvalid),
    .in_rdy_o  (i_tready),
    .out_dat_o (s1_dat),
    .out_vld_o (s1_vld),
    .out_rdy_i (s2_rdy)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: arithmetic shift, then saturate against the output range.
  // ---------------------------------------------------------------------------
  logic signed [WIDTH_IN:0] s1_sum_s;
  logic signed [WIDTH_IN:0] s2_shr;
  logic                     s1_last;
  logic [WIDTH_OUT-1:0]     s2_sat;
  logic                     s2_clip;

  assign s1_sum_s = $signed(s1_dat[WIDTH_IN:0]);
  assign s1_last  = s1_dat[WIDTH_IN+1];
  assign s2_shr   = s1_sum_s >>> SHIFT;

  always_comb begin
    s2_sat  = s2_shr[WIDTH_OUT-1:0];
    s2_clip = 1'b0;
    if (s2_shr > MAX_R) begin
      s2_sat  = SAT_POS;
      s2_clip = 1'b1;
    end else if (s2_shr < MIN_R) begin
      s2_sat  = SAT_NEG;
      s2_clip = 1'b1;
    end
  end

  logic [S2_W-1:0] s2_dat;

  // Output register resets its payload so o_tdata/o_tlast/o_tuser read 0 out of reset.
  axi_pipe_slice #(
    .W         (S2_W),
    .RESET_DAT (1'b1)
  ) u_s2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_dat_i  ({s2_clip, s1_last, s2_sat}),
    .in_vld_i  (s1_vld),
    .in_rdy_o  (s2_rdy),
    .out_dat_o (s2_dat),
    .out_vld_o (o_tvalid),
    .out_rdy_i (o_tready)
  );

  assign o_tdata = s2_dat[WIDTH_OUT-1:0];
  assign o_tlast = s2_dat[WIDTH_OUT];
  assign o_tuser = s2_dat[WIDTH_OUT+1];

  // ---------------------------------------------------------------------------
  // Clip status: counts clipped samples as they leave, not as they are computed,
  // so a stalled output is counted exactly once. clear has priority.
  // ---------------------------------------------------------------------------
  logic             clip_xfer;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  assign clip_xfer = o_tvalid & o_tready & o_tuser;

  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clear) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (clip_xfer) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign clip_cnt    = cnt_q;
  assign clip_sticky = sticky_q;

endmodule

// File: tb/tb_axi_round_clip_p.sv
// Directed bench for axi_round_clip_p (48 -> 16, shift 15, round half up).
// A second instance with a 4-bit clip counter shares all inputs to exercise counter saturation.
module tb_axi_round_clip_p;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [47:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        o_tready;

  logic        i_tready;
  logic [15:0] o_tdata;
  logic        o_tlast, o_tuser, o_tvalid, clip_sticky;
  logic [15:0] clip_cnt;

  logic        i_tready4;
  logic [15:0] o_tdata4;
  logic        o_tlast4, o_tuser4, o_tvalid4, clip_sticky4;
  logic [3:0]  clip_cnt4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_round_clip_p #(
    .WIDTH_IN(48), .WIDTH_OUT(16), .SHIFT(15), .ROUND(1), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tuser(o_tuser), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .clip_sticky(clip_sticky), .clip_cnt(clip_cnt)
  );

  axi_round_clip_p #(
    .WIDTH_IN(48), .WIDTH_OUT(16), .SHIFT(15), .ROUND(1), .CNT_W(4)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready4),
    .o_tdata(o_tdata4), .o_tlast(o_tlast4), .o_tuser(o_tuser4), .o_tvalid(o_tvalid4),
    .o_tready(o_tready), .clip_sticky(clip_sticky4), .clip_cnt(clip_cnt4)
  );

  // Reference: sign-extend, add half an output LSB, floor-shift, clamp. Returns {clipped, sample}.
  function automatic logic [16:0] model(input logic [47:0] x);
    longint v;
    longint r;
    logic [15:0] d;
    logic u;
    v = longint'($signed(x));
    r = (v + 64'sd16384) >>> 15;
    u = 1'b0;
    if (r > 32767) begin
      d = 16'h7FFF; u = 1'b1;
    end else if (r < -32768) begin
      d = 16'h8000; u = 1'b1;
    end else begin
      d = r[15:0];
    end
    return {u, d};
  endfunction

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0; o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_o_tvalid: got %b want 0", o_tvalid); end
    checks++; if (o_tdata !== 16'h0) begin errors++; $display("FAIL reset_o_tdata: got %h want 0000", o_tdata); end
    checks++; if ({o_tlast, o_tuser} !== 2'b00) begin errors++; $display("FAIL reset_tlast_tuser: got %b want 00", {o_tlast, o_tuser}); end
    checks++; if (clip_sticky !== 1'b0 || clip_cnt !== 16'h0) begin errors++; $display("FAIL reset_clip: got sticky=%b cnt=%0d want 0/0", clip_sticky, clip_cnt); end
    checks++; if (clip_cnt4 !== 4'h0) begin errors++; $display("FAIL reset_clip_cnt4: got %0d want 0", clip_cnt4); end
    checks++; if (i_tready !== 1'b1) begin errors++; $display("FAIL reset_i_tready: got %b want 1", i_tready); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_rounding();
    logic [47:0] vin [4];
    logic [15:0] vexp [4];
    vin[0] = 48'h0000_0000_3FFF; vexp[0] = 16'h0000;
    vin[1] = 48'h0000_0000_4000; vexp[1] = 16'h0001;
    vin[2] = 48'h0000_0000_C000; vexp[2] = 16'h0002;
    vin[3] = 48'hFFFF_FFFF_C000; vexp[3] = 16'h0000;
    o_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_tvalid = 1'b1; i_tdata = vin[k]; i_tlast = k[0];
      #1;
      checks++; if (i_tready !== 1'b1) begin errors++; $display("FAIL round_i_tready[%0d]: got %b want 1", k, i_tready); end
      tick();
      i_tvalid = 1'b0;
      #1;
      checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL round_early_valid[%0d]: got %b want 0", k, o_tvalid); end
      tick();
      #1;
      checks++;
      if (o_tvalid !== 1'b1 || o_tdata !== vexp[k] || o_tuser !== 1'b0 || o_tlast !== k[0]) begin
        errors++;
        $display("FAIL round_out[%0d]: got v=%b d=%h u=%b l=%b want v=1 d=%h u=0 l=%b",
                 k, o_tvalid, o_tdata, o_tuser, o_tlast, vexp[k], k[0]);
      end
      tick();
    end
    i_tlast = 1'b0;
  endtask

  task automatic test_saturation();
    logic [47:0] vin [4];
    logic [16:0] vexp [4];
    int sent = 0;
    int got = 0;
    vin[0] = 48'h0000_4000_0000; vexp[0] = {1'b1, 16'h7FFF};
    vin[1] = 48'h7FFF_FFFF_FFFF; vexp[1] = {1'b1, 16'h7FFF};  // full scale must not wrap negative
    vin[2] = 48'hFFFF_C000_0000; vexp[2] = {1'b0, 16'h8000};  // rounds to exactly -32768: in range
    vin[3] = 48'h8000_0000_0000; vexp[3] = {1'b1, 16'h8000};
    o_tready = 1'b1; i_tlast = 1'b0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      i_tvalid = (sent < 4);
      if (sent < 4) i_tdata = vin[sent];
      #1;
      if (o_tvalid) begin
        checks++;
        if ({o_tuser, o_tdata} !== vexp[got] || c != got + 2) begin
          errors++;
          $display("FAIL sat_out[%0d]: got u=%b d=%h at cycle %0d want u=%b d=%h at cycle %0d",
                   got, o_tuser, o_tdata, c, vexp[got][16], vexp[got][15:0], got + 2);
        end
        got++;
      end
      if (i_tvalid && i_tready) sent++;
      tick();
    end
    i_tvalid = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL sat_count: got %0d outputs want 4", got); end
    tick(); tick();
    checks++; if (clip_cnt !== 16'd3 || clip_sticky !== 1'b1) begin errors++; $display("FAIL sat_clip_status: got cnt=%0d sticky=%b want 3/1", clip_cnt, clip_sticky); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int first_c = -1;
    int last_c = -1;
    o_tready = 1'b0; i_tlast = 1'b0;
    for (int c = 0; c < 6; c++) begin
      i_tvalid = 1'b1; i_tdata = 48'(sent + 1) << 15;
      #1;
      if (c >= 2) begin
        checks++;
        if (i_tready !== 1'b0 || o_tvalid !== 1'b1 || o_tdata !== 16'd1) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h want rdy=0 v=1 d=0001", c, i_tready, o_tvalid, o_tdata);
        end
      end
      if (i_tready) sent++;
      tick();
    end
    checks++; if (sent != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", sent); end
    for (int c = 0; c < 20 && got < 5; c++) begin
      o_tready = 1'b1;
      i_tvalid = (sent < 5);
      i_tdata = 48'(sent + 1) << 15;
      #1;
      if (o_tvalid) begin
        checks++;
        if (o_tdata !== 16'(got + 1)) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", got, o_tdata, 16'(got + 1)); end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (i_tvalid && i_tready) sent++;
      tick();
    end
    i_tvalid = 1'b0;
    checks++; if (got != 5 || last_c - first_c != 4) begin errors++; $display("FAIL bp_drain: got %0d outputs over %0d cycles want 5 over 4", got, last_c - first_c); end
    tick(); #1;
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got o_tvalid=%b want 0", o_tvalid); end
    tick();
  endtask

  task automatic test_random_stall();
    logic [17:0] exq [$];
    logic [17:0] e;
    logic [63:0] rnd;
    logic [47:0] x;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit pend = 1'b0;
    i_tvalid = 1'b0;
    while (got < 200 && cyc < 4000) begin
      if (!pend && sent < 200 && $urandom_range(0, 3) != 0) begin
        rnd = {$urandom, $urandom};
        case ($urandom_range(0, 2))
          0:       x = rnd[47:0];
          1:       x = {{17{rnd[30]}}, rnd[30:0]};
          default: x = {{33{rnd[14]}}, rnd[14:0]};
        endcase
        i_tdata = x; i_tlast = (sent % 8 == 7); i_tvalid = 1'b1; pend = 1'b1;
      end
      o_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (o_tvalid && o_tready) begin
        checks++;
        if (exq.size() == 0) begin
          errors++; $display("FAIL rand_unexpected: output d=%h with empty scoreboard", o_tdata);
        end else begin
          e = exq.pop_front();
          if ({o_tlast, o_tuser, o_tdata} !== e) begin
            errors++;
            $display("FAIL rand_out[%0d]: got l=%b u=%b d=%h want l=%b u=%b d=%h",
                     got, o_tlast, o_tuser, o_tdata, e[17], e[16], e[15:0]);
          end
        end
        got++;
      end
      if (i_tvalid && i_tready) begin
        exq.push_back({i_tlast, model(i_tdata)});
        sent++; pend = 1'b0;
      end
      tick();
      cyc++;
      if (!pend) i_tvalid = 1'b0;
    end
    checks++; if (got != 200) begin errors++; $display("FAIL rand_count: got %0d outputs want 200", got); end
    o_tready = 1'b1; i_tvalid = 1'b0; i_tlast = 1'b0;
    tick(); tick();
  endtask

  task automatic test_counter();
    int sent = 0;
    int got = 0;
    o_tready = 1'b1; i_tlast = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    #1;
    checks++; if (clip_cnt !== 16'h0 || clip_cnt4 !== 4'h0 || clip_sticky !== 1'b0) begin errors++; $display("FAIL cnt_clear: got cnt=%0d cnt4=%0d sticky=%b want 0/0/0", clip_cnt, clip_cnt4, clip_sticky); end
    for (int c = 0; c < 40 && got < 20; c++) begin
      i_tvalid = (sent < 20); i_tdata = 48'h7FFF_FFFF_FFFF;
      #1;
      if (o_tvalid) got++;
      if (i_tvalid && i_tready) sent++;
      tick();
    end
    i_tvalid = 1'b0;
    tick(); #1;
    checks++; if (clip_cnt4 !== 4'hF || clip_sticky4 !== 1'b1) begin errors++; $display("FAIL cnt_saturate: got cnt4=%0d sticky4=%b want 15/1", clip_cnt4, clip_sticky4); end
    checks++; if (clip_cnt !== 16'd20) begin errors++; $display("FAIL cnt_wide: got %0d want 20", clip_cnt); end
    // Clear lands on the same edge as a clipped transfer.
    tick();
    i_tvalid = 1'b1; i_tdata = 48'h7FFF_FFFF_FFFF;
    #1; tick();
    i_tvalid = 1'b0;
    tick(); #1;
    checks++; if (o_tvalid !== 1'b1 || o_tdata !== 16'h7FFF || o_tuser !== 1'b1) begin errors++; $display("FAIL cnt_clip_out: got v=%b d=%h u=%b want 1/7fff/1", o_tvalid, o_tdata, o_tuser); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    checks++; if (clip_cnt4 !== 4'h0 || clip_cnt !== 16'h0 || clip_sticky !== 1'b0 || clip_sticky4 !== 1'b0) begin errors++; $display("FAIL cnt_clear_wins: got cnt=%0d cnt4=%0d sticky=%b want 0/0/0", clip_cnt, clip_cnt4, clip_sticky); end
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL cnt_clear_datapath: got o_tvalid=%b want 0", o_tvalid); end
    // One more clipped sample counts from zero again.
    tick();
    i_tvalid = 1'b1; i_tdata = 48'h8000_0000_0000;
    #1; tick();
    i_tvalid = 1'b0;
    tick(); tick(); #1;
    checks++; if (clip_cnt4 !== 4'h1 || clip_cnt !== 16'h1 || clip_sticky !== 1'b1) begin errors++; $display("FAIL cnt_after_clear: got cnt=%0d cnt4=%0d sticky=%b want 1/1/1", clip_cnt, clip_cnt4, clip_sticky); end
  endtask

  task automatic test_midstream_reset();
    int sent = 0;
    int got = 0;
    o_tready = 1'b0; i_tlast = 1'b0;
    i_tvalid = 1'b1; i_tdata = 48'(7) << 15;
    tick();
    i_tdata = 48'(8) << 15;
    tick();
    i_tvalid = 1'b0;
    #1;
    checks++; if (o_tvalid !== 1'b1 || o_tdata !== 16'd7 || i_tready !== 1'b0) begin errors++; $display("FAIL rst_full: got v=%b d=%h rdy=%b want 1/0007/0", o_tvalid, o_tdata, i_tready); end
    reset_n = 1'b0;
    #1;
    checks++; if (o_tvalid !== 1'b0 || o_tdata !== 16'h0) begin errors++; $display("FAIL rst_async_out: got v=%b d=%h want 0/0000", o_tvalid, o_tdata); end
    checks++; if (clip_cnt !== 16'h0 || clip_cnt4 !== 4'h0 || clip_sticky !== 1'b0) begin errors++; $display("FAIL rst_async_cnt: got cnt=%0d cnt4=%0d sticky=%b want 0/0/0", clip_cnt, clip_cnt4, clip_sticky); end
    tick();
    reset_n = 1'b1;
    o_tready = 1'b1;
    i_tvalid = 1'b1; i_tdata = 48'(9) << 15;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c == 0) begin
        checks++; if (i_tready !== 1'b1) begin errors++; $display("FAIL rst_first_accept: got i_tready=%b want 1", i_tready); end
      end
      if (o_tvalid) begin
        checks++;
        if (got == 0 && (o_tdata !== 16'd9 || c != 2)) begin errors++; $display("FAIL rst_first_out: got d=%h at cycle %0d want 0009 at cycle 2", o_tdata, c); end
        got++;
      end
      if (i_tvalid && i_tready) sent++;
      tick();
      if (sent > 0) i_tvalid = 1'b0;
    end
    checks++; if (got != 1) begin errors++; $display("FAIL rst_no_stale: got %0d outputs want 1", got); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_random_stall();
    test_counter();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
